// File: rtl/ram_read_controller_pkg.sv
// Shared widths and FSM encoding for the C-matrix row read/write controllers.
// The row bus carries N_COLS data words plus one checksum word on top.
package ram_read_controller_pkg;

  localparam int DATA_W    = 32;
  localparam int N_COLS    = 32;
  localparam int N_ROWS    = 32;
  localparam int ROW_W     = (N_COLS + 1) * DATA_W;
  localparam int COL_W     = $clog2(N_COLS);
  localparam int ROW_CNT_W = $clog2(N_ROWS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;

endpackage

// File: rtl/ram_read_controller_if.sv
// Bus between the row read controller, its operand RAM and the row consumer.
// Handshake: load_A is sampled only while the controller is idle (no queueing);
// load_A_ready is a one-cycle pulse with no back-pressure, dataAf_out is valid
// on that pulse and holds until the next one; ram_rdata follows ram_en by one cycle.
interface ram_read_controller_if #(
  parameter int ADDR_W = 10
);

  logic                                         load_A;
  logic                                         ram_en;
  logic [ADDR_W-1:0]                            ram_addr;
  logic [ram_read_controller_pkg::DATA_W-1:0]   ram_rdata;
  logic [ram_read_controller_pkg::ROW_W-1:0]    dataAf_out;
  logic                                         load_A_ready;
  logic                                         finish;

  modport master (
    input  load_A, ram_rdata,
    output ram_en, ram_addr, dataAf_out, load_A_ready, finish
  );

  modport slave (
    output load_A, ram_rdata,
    input  ram_en, ram_addr, dataAf_out, load_A_ready, finish
  );

endinterface

// File: rtl/ram_read_controller_checksum.sv
// Running modulo-2^W sum of row words; shared by the reader (generate) and
// the writer (verify) checksum paths.
module row_checksum_acc #(
  parameter int W = ram_read_controller_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         add_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/ram_read_controller.sv
// Fetches one operand row per load_A from a synchronous RAM and presents it,
// with an appended checksum word, on the wide fault-tolerant row bus.
module ram_read_controller
  import ram_read_controller_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_read_controller_if.master bus,
  output logic [1:0]           state_dbg
);

  logic [1:0]                       state;
  logic [COL_W-1:0]                 col;
  logic [COL_W-1:0]                 rd_col;
  logic                             rd_pending;
  logic [ROW_CNT_W-1:0]             row;
  logic [N_COLS-1:0][DATA_W-1:0]    shadow;
  logic [DATA_W-1:0]                acc_sum;
  logic                             acc_clear;

  assign state_dbg = state;
  assign acc_clear = (state == ST_EMIT);

  row_checksum_acc #(.W(DATA_W)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .add_en (rd_pending),
    .din    (bus.ram_rdata),
    .sum    (acc_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      col              <= '0;
      rd_col           <= '0;
      rd_pending       <= 1'b0;
      row              <= '0;
      shadow           <= '0;
      bus.ram_en       <= 1'b0;
      bus.ram_addr     <= '0;
      bus.dataAf_out   <= '0;
      bus.load_A_ready <= 1'b0;
      bus.finish       <= 1'b0;
    end else begin
      bus.load_A_ready <= 1'b0;
      bus.finish       <= 1'b0;
      // Read data returns one cycle after issue, so remember which slot it fills.
      rd_pending       <= bus.ram_en;
      rd_col           <= col;
      if (rd_pending) begin
        shadow[rd_col] <= bus.ram_rdata;
      end

      case (state)
        ST_IDLE: begin
          if (bus.load_A) begin
            state        <= ST_READ;
            col          <= '0;
            bus.ram_en   <= 1'b1;
            bus.ram_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(row) * ADDR_W'(N_COLS);
          end
        end
        ST_READ: begin
          if (col == COL_W'(N_COLS - 1)) begin
            state      <= ST_DRAIN;
            bus.ram_en <= 1'b0;
          end else begin
            col          <= col + COL_W'(1);
            bus.ram_addr <= bus.ram_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          state <= ST_EMIT;
        end
        ST_EMIT: begin
          bus.dataAf_out   <= {acc_sum, shadow};
          bus.load_A_ready <= 1'b1;
          if (row == ROW_CNT_W'(N_ROWS - 1)) begin
            bus.finish <= 1'b1;
            row        <= '0;
          end else begin
            row <= row + ROW_CNT_W'(1);
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_read_controller.sv
// Directed bench for ram_read_controller: expected rows, addresses, ready
// timing and finish flags are queued at request time and checked by a monitor.
module tb_ram_read_controller;
  import ram_read_controller_pkg::*;

  localparam int ADDR_W   = 10;
  localparam int MEM_SIZE = 1 << ADDR_W;
  localparam int LAT      = N_COLS + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ram_read_controller_if #(.ADDR_W(ADDR_W)) bus ();
  logic [1:0] state_dbg;

  ram_read_controller #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  // Synchronous single-port RAM model
  logic [DATA_W-1:0] mem [MEM_SIZE];
  always @(posedge clk) if (bus.ram_en) bus.ram_rdata <= mem[bus.ram_addr];

  // ---------------- scoreboard ----------------
  logic [ROW_W-1:0]  exp_q[$];
  int                exp_cyc_q[$];
  logic              exp_fin_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int vectors = 0;
  int miscompares = 0;
  int tb_row = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void check_row(logic [ROW_W-1:0] act, logic [ROW_W-1:0] exp);
    int bad;
    vectors++;
    if (act !== exp) begin
      miscompares++;
      bad = 0;
      for (int k = N_COLS; k >= 0; k--)
        if (act[k*DATA_W +: DATA_W] !== exp[k*DATA_W +: DATA_W]) bad = k;
      $display("FAIL row_data word %0d: got %h expected %h (cycle %0d)", bad,
               act[bad*DATA_W +: DATA_W], exp[bad*DATA_W +: DATA_W], cyc);
    end
  endfunction

  function automatic void flush_expectations();
    exp_q.delete();
    exp_cyc_q.delete();
    exp_fin_q.delete();
    exp_addr_q.delete();
    tb_row = 0;
  endfunction

  // Queue everything the DUT must produce for row tb_row sampled at edge t.
  function automatic void push_row(int t);
    logic [ROW_W-1:0]  r;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] w;
    r = '0;
    s = '0;
    for (int k = 0; k < N_COLS; k++) begin
      w = mem[tb_row * N_COLS + k];
      r[k*DATA_W +: DATA_W] = w;
      s = s + w;
      exp_addr_q.push_back(ADDR_W'(tb_row * N_COLS + k));
    end
    r[N_COLS*DATA_W +: DATA_W] = s;
    exp_q.push_back(r);
    exp_cyc_q.push_back(t + LAT);
    exp_fin_q.push_back(tb_row == N_ROWS - 1);
    tb_row = (tb_row + 1) % N_ROWS;
  endfunction

  always @(negedge clk) begin
    if (bus.ram_en === 1'b1) begin
      if (exp_addr_q.size() == 0) check("unexpected_ram_en", 64'(bus.ram_en), 64'd0);
      else check("ram_addr", 64'(bus.ram_addr), 64'(exp_addr_q.pop_front()));
    end
    if (bus.load_A_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'(bus.load_A_ready), 64'd0);
      end else begin
        check_row(bus.dataAf_out, exp_q.pop_front());
        check("ready_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
        check("finish", 64'(bus.finish), 64'(exp_fin_q.pop_front()));
      end
    end else if (bus.finish === 1'b1) begin
      check("finish_without_ready", 64'(bus.finish), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_outputs_zero(string tag);
    check({tag, "_ram_en"}, 64'(bus.ram_en), 64'd0);
    check({tag, "_ram_addr"}, 64'(bus.ram_addr), 64'd0);
    check({tag, "_data"}, 64'(bus.dataAf_out != '0), 64'd0);
    check({tag, "_ready"}, 64'(bus.load_A_ready), 64'd0);
    check({tag, "_finish"}, 64'(bus.finish), 64'd0);
    check({tag, "_state"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  task automatic do_reset(input int n, input logic hold_load);
    @(negedge clk);
    rst = 1'b1;
    bus.load_A = hold_load;
    @(posedge clk);
    flush_expectations();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs_zero("reset");
    end
    rst = 1'b0;
    bus.load_A = 1'b0;
  endtask

  // Call at a negedge with the DUT idle; returns at a negedge.
  task automatic request();
    bus.load_A = 1'b1;
    push_row(cyc + 1);
    @(posedge clk);
    @(negedge clk);
    bus.load_A = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && state_dbg == ST_IDLE) ok = 1'b1;
    end
    check("wait_idle_timeout", 64'(ok), 64'd1);
  endtask

  task automatic fill_ramp(input int offset);
    for (int a = 0; a < MEM_SIZE; a++) mem[a] = DATA_W'(a + offset);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    int t0;
    bus.load_A = 1'b0;
    for (int a = 0; a < MEM_SIZE; a++) mem[a] = '0;

    // Reset with load_A held high
    do_reset(3, 1'b1);

    // Single row: RAM[k] = k+1
    for (int k = 0; k < N_COLS; k++) mem[k] = DATA_W'(k + 1);
    request();
    wait_idle(LAT + 10);
    check("single_word0", 64'(bus.dataAf_out[DATA_W-1:0]), 64'd1);
    check("single_word31", 64'(bus.dataAf_out[31*DATA_W +: DATA_W]), 64'd32);
    check("single_checksum", 64'(bus.dataAf_out[N_COLS*DATA_W +: DATA_W]), 64'h210);

    // Checksum overflow on row 0
    do_reset(1, 1'b0);
    for (int k = 0; k < N_COLS; k++) mem[k] = 32'hFFFF_FFFF;
    request();
    wait_idle(LAT + 10);
    check("overflow_checksum", 64'(bus.dataAf_out[N_COLS*DATA_W +: DATA_W]), 64'hFFFF_FFE0);
    check("overflow_word7", 64'(bus.dataAf_out[7*DATA_W +: DATA_W]), 64'hFFFF_FFFF);

    // Full matrix plus one wrap-around row, RAM[a] = a
    do_reset(1, 1'b0);
    fill_ramp(0);
    for (int r = 0; r < N_ROWS + 1; r++) begin
      request();
      wait_idle(LAT + 10);
    end
    check("wrap_row0_word5", 64'(bus.dataAf_out[5*DATA_W +: DATA_W]), 64'd5);
    check("wrap_row0_checksum", 64'(bus.dataAf_out[N_COLS*DATA_W +: DATA_W]), 64'd496);

    // load_A held high: rows 1..3 back to back at the minimum spacing
    bus.load_A = 1'b1;
    t0 = cyc + 1;
    push_row(t0);
    push_row(t0 + LAT + 1);
    push_row(t0 + 2 * (LAT + 1));
    for (int i = 0; i < 200 && cyc < t0 + 2 * (LAT + 1) + 1; i++) @(negedge clk);
    bus.load_A = 1'b0;
    wait_idle(3 * LAT);

    // Mid-row reset while ram_addr = 10, then a clean row 0
    do_reset(1, 1'b0);
    fill_ramp(7);
    request();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.ram_en && bus.ram_addr == ADDR_W'(10)) found = 1'b1;
    end
    check("mid_reset_addr_reached", 64'(found), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    flush_expectations();
    @(negedge clk);
    check_outputs_zero("mid_reset");
    rst = 1'b0;
    request();
    wait_idle(LAT + 10);
    check("mid_reset_checksum", 64'(bus.dataAf_out[N_COLS*DATA_W +: DATA_W]), 64'd720);

    repeat (3) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
